// File: rtl/rrat_free_list_if.sv
// rrat_free_list_if: commit, dispatch and retirement-map bundle between the ROB/dispatch and the free list.
interface rrat_free_list_if #(
  parameter int PRF_SIZE  = 64,
  parameter int ARCH_REGS = 32,
  parameter int PRF_LEN   = $clog2(PRF_SIZE),
  parameter int FL_DEPTH  = PRF_SIZE - ARCH_REGS
);
  logic                           commit_valid;
  logic [4:0]                     rob_commit_dest_areg_idx;
  logic [PRF_LEN-1:0]             rob_commit_dest_preg_idx;
  logic                           mis_pred_is_head;
  logic                           dispatch_alloc;
  logic [PRF_LEN-1:0]             prf_free_preg_idx;
  logic                           free_preg_valid;
  logic [$clog2(FL_DEPTH):0]      free_count;
  logic [ARCH_REGS*PRF_LEN-1:0]   rrat_map;
  logic                           commit_mismatch;
  modport master (
    output commit_valid, rob_commit_dest_areg_idx, rob_commit_dest_preg_idx, mis_pred_is_head, dispatch_alloc,
    input  prf_free_preg_idx, free_preg_valid, free_count, rrat_map, commit_mismatch
  );
  modport slave (
    input  commit_valid, rob_commit_dest_areg_idx, rob_commit_dest_preg_idx, mis_pred_is_head, dispatch_alloc,
    output prf_free_preg_idx, free_preg_valid, free_count, rrat_map, commit_mismatch
  );
endinterface

// File: rtl/rrat_free_list.sv
// rrat_free_list: retirement RAT plus circular physical-register free list with one-cycle mispredict recovery.
module rrat_free_list #(
  parameter int PRF_SIZE  = 64,
  parameter int ARCH_REGS = 32,
  parameter int PRF_LEN   = $clog2(PRF_SIZE),
  parameter int FL_DEPTH  = PRF_SIZE - ARCH_REGS
) (
  input logic             clock,
  input logic             reset,
  rrat_free_list_if.slave bus
);
  localparam int PW = $clog2(FL_DEPTH);
  localparam int CW = PW + 1;
  logic [PRF_LEN-1:0] rrat [ARCH_REGS];
  logic [PRF_LEN-1:0] fl [FL_DEPTH];
  logic [PW-1:0] spec_head, ret_head, tail, ret_head_nxt;
  logic [CW-1:0] count;
  logic mismatch, do_commit, do_alloc, push, bad;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    do_commit    = bus.commit_valid && bus.rob_commit_dest_areg_idx != '0;
    do_alloc     = bus.dispatch_alloc && count != '0 && !bus.mis_pred_is_head;
    push         = do_commit && !(count == CW'(FL_DEPTH) && !do_alloc);
    bad          = do_commit && (!push || bus.rob_commit_dest_preg_idx != fl[ret_head]);
    ret_head_nxt = do_commit ? inc(ret_head) : ret_head;
  end
  // Recovery rewinds the speculative head onto the post-commit retirement head.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) rrat[i] <= PRF_LEN'(i);
      for (int i = 0; i < FL_DEPTH; i++) fl[i] <= PRF_LEN'(ARCH_REGS + i);
      spec_head <= '0;
      ret_head  <= '0;
      tail      <= '0;
      count     <= CW'(FL_DEPTH);
      mismatch  <= 1'b0;
    end else begin
      mismatch <= bad;
      ret_head <= ret_head_nxt;
      if (do_commit) rrat[bus.rob_commit_dest_areg_idx] <= bus.rob_commit_dest_preg_idx;
      if (push) begin
        fl[tail] <= rrat[bus.rob_commit_dest_areg_idx];
        tail     <= inc(tail);
      end
      spec_head <= bus.mis_pred_is_head ? ret_head_nxt : do_alloc ? inc(spec_head) : spec_head;
      count     <= bus.mis_pred_is_head ? CW'(FL_DEPTH) : count + CW'(push) - CW'(do_alloc);
    end
  end
  assign bus.prf_free_preg_idx = fl[spec_head];
  assign bus.free_preg_valid   = count != '0;
  assign bus.free_count        = count;
  assign bus.commit_mismatch   = mismatch;
  for (genvar g = 0; g < ARCH_REGS; g++) begin : g_map
    assign bus.rrat_map[g*PRF_LEN +: PRF_LEN] = rrat[g];
  end
endmodule

// File: doc/rrat_free_list.md
# rrat_free_list

Retirement-side companion to the reorder buffer. It consumes the ROB commit interface (`commit_valid`, `rob_commit_dest_areg_idx`, `rob_commit_dest_preg_idx`, `mis_pred_is_head`) and maintains two structures:
- the Retirement RAT (architectural register → physical register map);
- the physical-register free list that feeds `prf_free_preg_idx` at dispatch.

On a mispredict reaching the ROB head, it restores the free list to the committed state in one cycle.

## Interface
- `PRF_SIZE`, default 64: number of physical registers (power of two).
- `ARCH_REGS`, default 32: number of architectural registers. Free-list depth `FL_DEPTH = PRF_SIZE - ARCH_REGS`.
- `PRF_LEN`, default $clog2(PRF_SIZE): physical register index width.
- `clock`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `commit_valid`, in, 1: ROB head commits this cycle.
- `rob_commit_dest_areg_idx`, in, 5: committing destination architectural register.
- `rob_commit_dest_preg_idx`, in, PRF_LEN: committing destination physical register.
- `mis_pred_is_head`, in, 1: mispredicted branch is at the ROB head; triggers recovery.
- `dispatch_alloc`, in, 1: dispatch consumes the current free preg.
- `prf_free_preg_idx`, out, PRF_LEN: preg at the speculative free-list head.
- `free_preg_valid`, out, 1: free list is non-empty.
- `free_count`, out, $clog2(FL_DEPTH)+1: number of free pregs.
- `rrat_map`, out, ARCH_REGS*PRF_LEN: packed committed map; entry i sits at bits [i*PRF_LEN +: PRF_LEN].
- `commit_mismatch`, out, 1: one-cycle error pulse.

## Operation
- **State:**
  - RRAT table, ARCH_REGS × PRF_LEN;
  - free-list array, FL_DEPTH × PRF_LEN;
  - pointers `spec_head`, `ret_head`, `tail` (each mod FL_DEPTH);
  - `free_count`.
- **Reset (async):**
  - RRAT[i] = i;
  - fl[i] = ARCH_REGS + i;
  - `spec_head` = `ret_head` = `tail` = 0;
  - `free_count` = FL_DEPTH;
  - `commit_mismatch` = 0.
  - Resulting outputs: `prf_free_preg_idx` = ARCH_REGS, `free_preg_valid` = 1, `rrat_map` = identity.
- **Allocate.** Requires `dispatch_alloc` && `free_count` != 0 && !`mis_pred_is_head`.
  - `spec_head` increments with wrap.
  - `free_count` decrements.
  - If the list is empty, the allocate is ignored and state is unchanged.
- **Commit.** Requires `commit_valid` && areg != 0.
  - old = RRAT[areg].
  - RRAT[areg] = commit preg.
  - fl[tail] = old; `tail` increments.
  - `ret_head` increments.
  - `free_count` increments.
- **Commit with areg == 0:** treated as no destination. No RRAT write, no push, `ret_head` unchanged.
- **Mismatch check.** On a commit with a destination, compare commit preg against fl[`ret_head`] (pre-update).
  - If they differ, `commit_mismatch` = 1 for the next cycle only.
  - The update is still performed.
- **Recovery** (`mis_pred_is_head`):
  - Any same-cycle commit is applied first.
  - Then `spec_head` = the post-commit `ret_head`.
  - `free_count` = FL_DEPTH.
  - Any same-cycle allocate is dropped.
- **Alloc + commit in the same cycle:** both apply. `free_count` is unchanged; `spec_head`, `ret_head` and `tail` each advance.
- **Overflow guard.** A push when `free_count` == FL_DEPTH and no same-cycle allocate cannot occur legally.
  - The push is dropped and `commit_mismatch` pulses.
- **Wrap-around.** All pointers wrap FL_DEPTH-1 → 0. Full and empty are distinguished only by `free_count`.

## Timing
- `prf_free_preg_idx` and `free_preg_valid` are combinational from registered state (fl[`spec_head`], `free_count`). Dispatch samples them in the same cycle it asserts `dispatch_alloc`.
- Allocate, commit and recovery take effect at the rising edge. The new head, map and count are visible one cycle later.
- A preg freed by a commit in cycle N is allocatable no earlier than cycle N+1, and only after all earlier free entries ahead of it.
- `commit_mismatch` is registered: it is high in cycle N+1 for an error in cycle N.
- Reset asserted mid-operation clears all state immediately, regardless of the clock.

## Test plan
- **Reset:** assert `reset` without clock edges → `rrat_map[5]` = 5, `prf_free_preg_idx` = 32, `free_count` = 32, `free_preg_valid` = 1, `commit_mismatch` = 0.
- **Allocate then commit:** allocate 3 cycles → pregs 32, 33, 34 issued, `free_count` = 29. Then commit areg 5 / preg 32 → `rrat_map[5]` = 32, fl[0] = 5, `free_count` = 30, no mismatch.
- **Recovery:** allocate 32, 33, 34; commit (5, 32); assert `mis_pred_is_head` with `dispatch_alloc` = 1 → allocate dropped, `prf_free_preg_idx` = 33, `free_count` = 32.
- **Empty + wrap:**
  - Allocate 32 times → `free_preg_valid` = 0; a 33rd `dispatch_alloc` leaves state unchanged.
  - Commit 32 destinations (areg 1..31 and 1 again) → tail wraps to 0.
  - A further allocate returns the first freed preg (the old mapping of areg 1 = 1).
- **Simultaneous alloc + commit with count 10:** `free_count` stays 10, all three pointers advance. A commit with areg 0 leaves `rrat_map` and `free_count` untouched.
- **Mismatch:** allocate 32, then commit (3, preg 40) → `commit_mismatch` high exactly one cycle and `rrat_map[3]` = 40.
